// File: rtl/cmos_cells_pkg.sv
// Shared cell-library constants and helpers for the flip-flop based pipeline blocks.
// Delay values are documentation of the primitive timing model; the RTL itself carries no delays.
package cmos_cells_pkg;

   localparam real TCQ    = 0.2;  // register clock-to-Q
   localparam real TGATE1 = 0.1;  // BUF/NOT
   localparam real TGATE2 = 0.2;  // NAND/NOR

   // Width needed to count 0..depth occupied stages.
   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: a valid/data register pair plus its ready term.
// Data only loads when an upstream beat is present, so idle stages do not toggle.
module dff_pipe_stage
   import cmos_cells_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             C,
   input  logic             RN,
   input  logic             VP,
   input  logic [WIDTH-1:0] DP,
   input  logic             RDYN,
   output logic             V,
   output logic [WIDTH-1:0] DQ,
   output logic             RDY
);

   logic             v_d, v_q;
   logic [WIDTH-1:0] d_d, d_q;

   // Empty stages accept regardless of downstream, which is what collapses bubbles.
   assign RDY = ~v_q | RDYN;

   always_comb begin
      // NOTE: defaults first so every path assigns v_d/d_d and no latch is inferred.
      v_d = v_q;
      d_d = d_q;
      if (RDY) begin
         v_d = VP;
         if (VP) d_d = DP;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
   always_ff @(posedge C) begin
      if (!RN) begin
         // NOTE: data registers are reset too, so Q reads 0 out of reset rather than stale data.
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign V  = v_q;
   assign DQ = d_q;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage elastic register pipeline with valid/ready flow control and occupancy count.
// Optional flush path enabled by defining DFF_PIPE_FLUSH_EN (adds the FLUSH input).
module dff_pipe
   import cmos_cells_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     C,
   input  logic                     RN,
   input  logic                     VI,
   input  logic [WIDTH-1:0]         D,
   output logic                     RI,
   output logic                     VO,
   output logic [WIDTH-1:0]         Q,
   input  logic                     RO,
`ifdef DFF_PIPE_FLUSH_EN
   input  logic                     FLUSH,
`endif
   output logic [occ_w(DEPTH)-1:0]  OCC
);

   localparam int OCC_W = occ_w(DEPTH);

   logic             flush;
   logic [DEPTH-1:0] v_all;
   logic [OCC_W-1:0] occ_c;

`ifdef DFF_PIPE_FLUSH_EN
   assign flush = FLUSH;
`else
   assign flush = 1'b0;
`endif

   // Flush forces every stage ready with no incoming valid: all valids clear, data holds.
   for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
      logic             vp;
      logic [WIDTH-1:0] dp;
      logic             rdyn;
      logic             v;
      logic [WIDTH-1:0] dq;
      logic             rdy;

      if (k == 1) begin : g_head
         assign vp = VI & ~flush;
         assign dp = D;
      end else begin : g_link
         assign vp = g_stg[k-1].v & ~flush;
         assign dp = g_stg[k-1].dq;
      end

      if (k == DEPTH) begin : g_tail
         assign rdyn = RO | flush;
      end else begin : g_body
         assign rdyn = g_stg[k+1].rdy | flush;
      end

      dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .C    (C),
         .RN   (RN),
         .VP   (vp),
         .DP   (dp),
         .RDYN (rdyn),
         .V    (v),
         .DQ   (dq),
         .RDY  (rdy)
      );

      assign v_all[k-1] = v;
   end

   always_comb begin
      occ_c = '0;
      for (int k = 0; k < DEPTH; k++) occ_c = occ_c + OCC_W'(v_all[k]);
   end

   assign OCC = occ_c;
   assign RI  = g_stg[1].rdy & ~flush;
   assign VO  = g_stg[DEPTH].v;
   assign Q   = g_stg[DEPTH].dq;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4) plus a DEPTH=1 boundary instance.
// Define DFF_PIPE_FLUSH_EN to also exercise the flush path.
module tb_dff_pipe;

   logic       C = 1'b0;
   logic       RN, VI, RO;
   logic [7:0] D;
   logic       RI, VO;
   logic [7:0] Q;
   logic [2:0] OCC;
`ifdef DFF_PIPE_FLUSH_EN
   logic       FLUSH;
`endif

   logic       vi1, ro1, ri1, vo1;
   logic [7:0] d1, q1;
   logic       occ1;

   int checks = 0;
   int errors = 0;

   always #5 C = ~C;

   dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
      .C(C), .RN(RN), .VI(VI), .D(D), .RI(RI), .VO(VO), .Q(Q), .RO(RO),
`ifdef DFF_PIPE_FLUSH_EN
      .FLUSH(FLUSH),
`endif
      .OCC(OCC)
   );

   dff_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
      .C(C), .RN(RN), .VI(vi1), .D(d1), .RI(ri1), .VO(vo1), .Q(q1), .RO(ro1),
`ifdef DFF_PIPE_FLUSH_EN
      .FLUSH(1'b0),
`endif
      .OCC(occ1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are then driven 1 time unit after the edge.
   task automatic tick();
      @(posedge C);
      #1;
   endtask

   initial begin
      logic [7:0] exp_head [6];
      bit         found;

      RN = 1'b0; VI = 1'b1; D = 8'hA5; RO = 1'b0;
      vi1 = 1'b0; d1 = 8'h00; ro1 = 1'b0;
`ifdef DFF_PIPE_FLUSH_EN
      FLUSH = 1'b0;
`endif
      // Reset for two edges while an input beat is offered.
      tick(); tick();
      check("rst_vo",  VO,  0);
      check("rst_q",   Q,   0);
      check("rst_occ", OCC, 0);
      check("rst_ri",  RI,  1);
      RN = 1'b1; VI = 1'b0; RO = 1'b1;

      // Streaming 01..10 with RO=1.
      for (int j = 1; j <= 19; j++) begin
         VI = (j <= 16);
         D  = (j <= 16) ? 8'(j) : 8'h00;
         #1;
         if (j <= 16) check($sformatf("strm_ri_%0d", j), RI, 1);
         tick();
         if (j < 4) check($sformatf("strm_vo_pre_%0d", j), VO, 0);
         else begin
            check($sformatf("strm_vo_%0d", j), VO, 1);
            check($sformatf("strm_q_%0d", j), Q, j - 3);
            if (j <= 16) check($sformatf("strm_occ_%0d", j), OCC, 4);
         end
      end
      VI = 1'b0;
      tick();
      check("strm_drain_occ", OCC, 0);
      check("strm_drain_vo", VO, 0);

      // Back-pressure: 4 beats fill the pipe, then RI drops.
      RO = 1'b0;
      for (int i = 0; i < 4; i++) begin
         VI = 1'b1; D = 8'h21 + 8'(i);
         #1;
         check($sformatf("bp_ri_%0d", i), RI, 1);
         tick();
      end
      VI = 1'b1; D = 8'h25;
      #1;
      check("bp_full_ri",  RI,  0);
      check("bp_full_occ", OCC, 4);
      check("bp_full_vo",  VO,  1);
      check("bp_full_q",   Q,   8'h21);
      tick();
      check("bp_hold_occ", OCC, 4);
      check("bp_hold_q",   Q,   8'h21);
      exp_head = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
      RO = 1'b1;
      for (int c = 0; c < 6; c++) begin
         VI = (c < 2);
         D  = (c == 0) ? 8'h25 : 8'h26;
         #1;
         if (c < 2) check($sformatf("bp_ri_rel_%0d", c), RI, 1);
         if (c < 2) check($sformatf("bp_occ_rel_%0d", c), OCC, 4);
         check($sformatf("bp_vo_%0d", c), VO, 1);
         check($sformatf("bp_q_%0d", c),  Q,  exp_head[c]);
         tick();
      end
      VI = 1'b0;
      #1;
      check("bp_empty_occ", OCC, 0);
      check("bp_empty_ri",  RI,  1);

      // Bubble collapse: beats at edges 0 and 3 with RO=0.
      RO = 1'b0;
      for (int e = 0; e <= 4; e++) begin
         VI = (e == 0 || e == 3);
         D  = (e == 0) ? 8'h31 : 8'h32;
         tick();
      end
      VI = 1'b0;
      #1;
      check("bub_occ", OCC, 2);
      check("bub_vo",  VO,  1);
      check("bub_q",   Q,   8'h31);
      check("bub_ri",  RI,  1);
      RO = 1'b1;
      tick();
      check("bub_occ_after", OCC, 1);
      found = 1'b0;
      for (int w = 0; w < 4 && !found; w++) begin
         if (VO) begin
            check("bub_second_q", Q, 8'h32);
            found = 1'b1;
         end else tick();
      end
      check("bub_second_seen", found, 1);
      tick();
      check("bub_empty_occ", OCC, 0);

      // Mid-stream reset with three beats in flight.
      RO = 1'b0;
      for (int i = 0; i < 3; i++) begin
         VI = 1'b1; D = 8'h41 + 8'(i);
         tick();
      end
      VI = 1'b0;
      #1;
      check("mrst_pre_occ", OCC, 3);
      RN = 1'b0;
      tick();
      check("mrst_occ", OCC, 0);
      check("mrst_vo",  VO,  0);
      check("mrst_q",   Q,   0);
      check("mrst_ri",  RI,  1);
      RN = 1'b1; RO = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("mrst_no_old_%0d", i), VO, 0);
      end

`ifdef DFF_PIPE_FLUSH_EN
      // Flush a full pipe while an output and an input are both offered.
      RO = 1'b0;
      for (int i = 0; i < 4; i++) begin
         VI = 1'b1; D = 8'h51 + 8'(i);
         tick();
      end
      RO = 1'b1; VI = 1'b1; D = 8'h5F; FLUSH = 1'b1;
      #1;
      check("fl_occ_pre", OCC, 4);
      check("fl_vo",      VO,  1);
      check("fl_q",       Q,   8'h51);
      check("fl_ri",      RI,  0);
      tick();
      FLUSH = 1'b0; VI = 1'b0;
      #1;
      check("fl_occ", OCC, 0);
      check("fl_vo_after", VO, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("fl_no_beat_%0d", i), VO, 0);
      end
`endif

      // DEPTH=1 boundary: one-edge latency and RI = ~VO | RO.
      ro1 = 1'b0; vi1 = 1'b1; d1 = 8'h77;
      #1;
      check("d1_ri_empty", ri1, 1);
      tick();
      vi1 = 1'b0;
      #1;
      check("d1_vo",   vo1,  1);
      check("d1_q",    q1,   8'h77);
      check("d1_occ",  occ1, 1);
      check("d1_ri_stall", ri1, 0);
      ro1 = 1'b1;
      #1;
      check("d1_ri_ro", ri1, 1);
      tick();
      check("d1_drain_vo", vo1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
